// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package stream_demux_pkg;
  localparam int DEF_W     = 4;
  localparam int DEF_CNT_W = 8;
  localparam int N_OUT     = 4;

  typedef logic [1:0] sel_t;
endpackage

// File: rtl/stream_demux_1_4_slot.sv
// One output lane: a single-entry buffer plus a wrapping delivery counter.
module demux_slot import stream_demux_pkg::*; #(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [W-1:0]     i_data,
  input  logic             i_out_ready,
  output logic             o_full,
  output logic [W-1:0]     o_data,
  output logic [CNT_W-1:0] o_count
);
  logic             r_full;
  logic [W-1:0]     r_data;
  logic [CNT_W-1:0] r_count;
  logic             w_out_xfer;

  assign w_out_xfer = r_full & i_out_ready;

  // A write landing on the same edge as a drain keeps the slot full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full  <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      if (i_we) begin
        r_full <= 1'b1;
        r_data <= i_data;
      end else if (w_out_xfer) begin
        r_full <= 1'b0;
      end
      if (w_out_xfer)
        r_count <= r_count + 1'b1;
    end
  end

  assign o_full  = r_full;
  assign o_data  = r_data;
  assign o_count = r_count;
endmodule

// File: rtl/stream_demux_1_4.sv
// 1-to-4 stream demux: selector decode and ready mux; state lives in demux_slot.
module stream_demux_1_4 import stream_demux_pkg::*; #(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_data,
  input  logic [1:0]             in_sel,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*W-1:0]     out_data,
  output logic [N_OUT*CNT_W-1:0] out_count
);
  logic [N_OUT-1:0] w_full;
  logic [N_OUT-1:0] w_we;
  sel_t             w_sel;

  assign w_sel = sel_t'(in_sel);
  // Ready looks only at the addressed slot, so a stalled lane never blocks others.
  assign in_ready  = ~w_full[w_sel] | out_ready[w_sel];
  assign out_valid = w_full;

  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    assign w_we[i] = in_valid & in_ready & (w_sel == sel_t'(i));

    demux_slot #(.W(W), .CNT_W(CNT_W)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .i_we        (w_we[i]),
      .i_data      (in_data),
      .i_out_ready (out_ready[i]),
      .o_full      (w_full[i]),
      .o_data      (out_data[i*W +: W]),
      .o_count     (out_count[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed bench for stream_demux_1_4 with a per-cycle reference model.
module tb_stream_demux_1_4;
  localparam int W = 4;
  localparam int CNT_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
  logic [31:0] out_count;

  int checks = 0;
  int failures = 0;

  // Reference model: plain arrays, one entry per output.
  bit       full_m [4] = '{default: 1'b0};
  logic [3:0] data_m [4] = '{default: 4'h0};
  logic [7:0] cnt_m  [4] = '{default: 8'h0};

  stream_demux_1_4 #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    bit acc;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        full_m[i] = 1'b0; data_m[i] = 4'h0; cnt_m[i] = 8'h0;
      end
    end else begin
      acc = in_valid && (!full_m[in_sel] || out_ready[in_sel]);
      for (int i = 0; i < 4; i++)
        if (full_m[i] && out_ready[i]) begin
          cnt_m[i] = cnt_m[i] + 8'd1;
          full_m[i] = 1'b0;
        end
      if (acc) begin
        full_m[in_sel] = 1'b1;
        data_m[in_sel] = in_data;
      end
    end
  end

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      logic [3:0] v;
      logic [31:0] c;
      for (int i = 0; i < 4; i++) begin
        v[i] = full_m[i];
        c[i*8 +: 8] = cnt_m[i];
        if (full_m[i]) chk($sformatf("model_data%0d", i), out_data[i*4 +: 4], data_m[i]);
      end
      chk("model_valid", out_valid, v);
      chk("model_count", out_count, c);
      chk("model_ready", in_ready, !full_m[in_sel] || out_ready[in_sel]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_data = 0; in_sel = 0; out_ready = 4'b0000;
    tick(); tick();
    chk("rst_valid", out_valid, 4'b0000);
    chk("rst_count", out_count, 32'h0);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s); #1;
      chk($sformatf("rst_ready_sel%0d", s), in_ready, 1'b1);
    end

    // Routing
    out_ready = 4'b1111;
    in_valid = 1; in_sel = 0; in_data = 4'ha; tick();
    chk("route0_valid", out_valid, 4'b0001); chk("route0_data", out_data[3:0], 4'ha);
    in_sel = 1; in_data = 4'hb; tick();
    chk("route1_valid", out_valid, 4'b0010); chk("route1_data", out_data[7:4], 4'hb);
    in_sel = 2; in_data = 4'hc; tick();
    chk("route2_valid", out_valid, 4'b0100); chk("route2_data", out_data[11:8], 4'hc);
    in_sel = 3; in_data = 4'hd; tick();
    chk("route3_valid", out_valid, 4'b1000); chk("route3_data", out_data[15:12], 4'hd);
    in_valid = 0; tick();
    chk("route_count", out_count, 32'h01010101);

    // Backpressure on output 2
    out_ready = 4'b1011;
    in_valid = 1; in_sel = 2; in_data = 4'h5; tick();
    in_data = 4'h6; #1;
    chk("bp_ready_low", in_ready, 1'b0);
    tick();
    chk("bp_hold_data", out_data[11:8], 4'h5);
    chk("bp_hold_valid", out_valid[2], 1'b1);
    out_ready = 4'b1111; #1;
    chk("bp_ready_high", in_ready, 1'b1);
    tick();
    chk("bp_nobubble_valid", out_valid[2], 1'b1);
    chk("bp_nobubble_data", out_data[11:8], 4'h6);
    in_valid = 0; tick();
    chk("bp_count", out_count[23:16], 8'd3);

    // Stalled output 1 must not block output 3
    out_ready = 4'b0000;
    in_valid = 1; in_sel = 1; in_data = 4'h9; tick();
    in_sel = 3; in_data = 4'h7; #1;
    chk("nb_ready", in_ready, 1'b1);
    tick();
    chk("nb_valid", out_valid, 4'b1010);
    chk("nb_data3", out_data[15:12], 4'h7);
    chk("nb_data1", out_data[7:4], 4'h9);
    in_valid = 0; out_ready = 4'b1111; tick(); tick();

    // Counter wrap on output 0 from a clean start
    rst = 1; tick(); rst = 0;
    in_valid = 1; in_sel = 0;
    for (int k = 0; k < 256; k++) begin
      in_data = 4'(k); tick();
    end
    chk("wrap_ff", out_count[7:0], 8'hff);
    in_valid = 0; tick();
    chk("wrap_zero", out_count[7:0], 8'h00);

    // Async reset between edges with outputs 0 and 3 full
    out_ready = 4'b0000;
    in_valid = 1; in_sel = 0; in_data = 4'h3; tick();
    in_sel = 3; in_data = 4'he; tick();
    in_valid = 0;
    chk("ar_pre_valid", out_valid, 4'b1001);
    #2 rst = 1; #1;
    chk("ar_valid", out_valid, 4'b0000);
    chk("ar_count", out_count, 32'h0);
    tick(); rst = 0; tick();
    chk("ar_after_valid", out_valid, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stream_demux_1_4.md
STREAM_DEMUX_1_4 -- requirements
Module: stream_demux_1_4

Interface
REQ-001 Parameters SHALL be, one per line:
  W, 4, data width in bits.
  CNT_W, 8, width of each per-output delivery counter.
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock; all state updates on rising edge.
  rst  input  1  reset, asynchronous, active-high.
  in_valid  input  1  upstream word present.
  in_ready  output  1  block accepts the upstream word this cycle.
  in_data  input  W  upstream word.
  in_sel  input  2  destination output index 0..3, qualified by in_valid.
  out_valid  output  4  bit i: output i holds a word.
  out_ready  input  4  bit i: downstream i consumes this cycle.
  out_data  output  4*W  slice i (bits i*W+W-1 : i*W) is the word for output i.
  out_count  output  4*CNT_W  slice i is the count of words delivered on output i.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high, port names clk and rst.

Function
REQ-004 Each output i SHALL own a one-entry buffer: full flag (drives out_valid[i]) and data register (drives out_data slice i).
REQ-005 in_ready SHALL be combinational: in_ready = ~full[in_sel] | out_ready[in_sel]. It SHALL depend only on in_sel, full and out_ready, never on in_valid.
REQ-006 An input transfer SHALL occur when in_valid & in_ready. in_data SHALL then be written into buffer in_sel, and full[in_sel] SHALL be 1 next cycle.
REQ-007 An output transfer on i SHALL occur when out_valid[i] & out_ready[i]. full[i] SHALL clear next cycle unless a simultaneous input transfer targets i.
REQ-008 Simultaneous input and output transfer on the same i SHALL replace the buffer content with the new word and keep full[i]=1, with no bubble.
REQ-009 Latency SHALL be exactly one cycle: a word accepted in cycle n SHALL appear on out_valid/out_data of in_sel in cycle n+1.
REQ-010 Outputs SHALL be independent: a stalled output j (full, out_ready[j]=0) SHALL NOT block input words addressed to any other output.
REQ-011 Once out_valid[i]=1, out_data slice i SHALL remain stable until the output transfer on i occurs.
REQ-012 in_data and in_sel SHALL be ignored when in_valid=0; no buffer or counter SHALL change from input side.
REQ-013 out_count slice i SHALL increment by 1 on each output transfer on i and wrap from 2^CNT_W-1 to 0 with no flag.
REQ-014 Multiple outputs SHALL be able to complete output transfers in the same cycle, each counter updating independently.

Reset
REQ-015 Assertion of rst SHALL immediately clear all full flags (out_valid=0), all data registers (0) and all counters (0), with no clock required.
REQ-016 Reset mid-operation SHALL discard any buffered words; no output transfer SHALL be counted in a cycle where rst is high.
REQ-017 After rst deasserts, in_ready SHALL be 1 for every in_sel in the first cycle.

Structure
REQ-018 A shared package stream_demux_pkg SHALL hold W and CNT_W defaults, the output count constant N_OUT=4, and the selector typedef sel_t (2 bits).
REQ-019 The per-output buffer plus counter SHALL be one sub-module, demux_slot, instantiated four times; the top SHALL hold only sel decode and ready muxing.

Verification
REQ-020 Reset then idle: rst pulse with out_ready=0 -> out_valid=0000, all out_count=0, in_ready=1 for in_sel 0..3.
REQ-021 Routing: send 'ha,'hb,'hc,'hd to sel 0,1,2,3 back-to-back with out_ready=1111 -> each word appears on its output one cycle after acceptance; out_count each =1.
REQ-022 Backpressure: out_ready[2]=0, send 'h5 then 'h6 to sel 2 -> second word held (in_ready=0) and out_data slice 2 stays 'h5; raise out_ready[2] -> 'h6 follows with no bubble.
REQ-023 Non-blocking: output 1 full and stalled; send 'h7 to sel 3 -> accepted immediately, out_valid[3]=1 next cycle, output 1 unchanged.
REQ-024 Counter wrap (CNT_W=8): 256 transfers on output 0 -> out_count slice 0 returns to 0.
REQ-025 Async reset mid-stream: assert rst between clock edges with outputs 0 and 3 full -> out_valid drops to 0000 before the next edge; counters read 0.
